// File: rtl/csmulti_pipe.sv
// csmulti_pipe: pipelined WIDTH x WIDTH carry-save array multiplier with
// per-transaction unsigned/signed (Baugh-Wooley) mode and valid/ready
// handshakes. STAGES register levels split the array rows evenly; the last
// level also holds the vector-merging ripple adder and the product register.
module csmulti_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_signed
);

  localparam int P    = 2 * WIDTH;
  // Intermediate register levels (the final level is the product register).
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [P-1:0] ONE      = {{(P-1){1'b0}}, 1'b1};
  // Baugh-Wooley correction constants: +2^WIDTH and +2^(2*WIDTH-1).
  localparam logic [P-1:0] BW_CONST = (ONE << WIDTH) | (ONE << (P - 1));

  // Everything a partially reduced transaction carries between levels.
  typedef struct packed {
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [P-1:0]     sum;
    logic [P-1:0]     carry;
  } stage_t;

  // Array row after which register level k sits.
  function automatic int row_at(input int k);
    return (k * WIDTH) / STAGES;
  endfunction

  // Fold partial-product rows lo..hi-1 into the carry-save pair, one 3:2
  // compressor row each. In signed mode the bits pairing exactly one operand
  // MSB are inverted.
  function automatic stage_t add_rows(input stage_t s, input int lo, input int hi);
    stage_t       r;
    logic [P-1:0] pp;
    logic [P-1:0] sum_n;
    logic [P-1:0] carry_n;
    logic         pbit;
    r = s;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < hi) begin
        pp = '0;
        for (int j = 0; j < WIDTH; j++) begin
          pbit = r.a[j] & r.b[i];
          if (r.sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) pbit = ~pbit;
          pp[i+j] = pbit;
        end
        sum_n   = r.sum ^ r.carry ^ pp;
        carry_n = ((r.sum & r.carry) | (r.sum & pp) | (r.carry & pp)) << 1;
        r.sum   = sum_n;
        r.carry = carry_n;
      end
    end
    return r;
  endfunction

  // Vector-merging ripple adder; the carry out of the top bit is dropped
  // because the product is defined modulo 2^(2*WIDTH).
  function automatic logic [P-1:0] merge_add(input logic [P-1:0] x, input logic [P-1:0] y);
    logic [P-1:0] s;
    logic         c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < P; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return s;
  endfunction

  // Remaining rows plus the merge, for the last register level.
  function automatic logic [P-1:0] finish(input stage_t s);
    stage_t r;
    r = add_rows(s, row_at(STAGES - 1), WIDTH);
    return merge_add(r.sum, r.carry);
  endfunction

  logic             stall;
  logic             advance;
  stage_t           head;
  logic             head_vld;
  stage_t           stage_d [NREG];
  logic [NREG-1:0]  stage_vld_d;
  stage_t           data_q  [NREG];
  logic [NREG-1:0]  vld_q;
  stage_t           last_src;
  logic             last_vld;
  logic [P-1:0]     product_d;
  logic             out_valid_q;
  logic             out_signed_q;
  logic [P-1:0]     out_product_q;

  // A held output freezes the whole pipe; in_ready never looks at in_valid.
  assign stall       = out_valid_q & ~out_ready;
  assign advance     = ~stall;
  assign in_ready    = ~stall;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_signed  = out_signed_q;

  // Operand entry: seed the carry-save pair with the signed-mode constants.
  always_comb begin
    head_vld   = in_valid & in_ready;
    head.sgn   = in_signed;
    head.a     = in_a;
    head.b     = in_b;
    head.sum   = in_signed ? BW_CONST : '0;
    head.carry = '0;
  end

  // Row reduction feeding each intermediate register level.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit -- no latch.
    stage_d        = '{default: '0};
    stage_vld_d    = '0;
    stage_vld_d[0] = head_vld;
    stage_d[0]     = add_rows(head, row_at(0), row_at(1));
    for (int k = 1; k < NREG; k++) begin
      stage_vld_d[k] = vld_q[k-1];
      stage_d[k]     = add_rows(data_q[k-1], row_at(k), row_at(k + 1));
    end
  end

  // The final level is fed straight from the inputs when there is only one.
  if (STAGES == 1) begin : g_single
    assign last_src = head;
    assign last_vld = head_vld;
  end else begin : g_multi
    assign last_src = data_q[STAGES-2];
    assign last_vld = vld_q[STAGES-2];
  end

  // Final rows and merge into the full-width product.
  always_comb begin
    product_d = finish(last_src);
  end

  // Valid bits and output register: cleared asynchronously, all levels
  // advance together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every level samples pre-edge values.
    if (!rst_n) begin
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_signed_q  <= 1'b0;
    end else if (advance) begin
      vld_q       <= stage_vld_d;
      out_valid_q <= last_vld;
      if (last_vld) begin
        out_product_q <= product_d;
        out_signed_q  <= last_src.sgn;
      end
    end
  end

  // Intermediate datapath registers, loaded only when a real transaction arrives.
  always_ff @(posedge clk) begin
    // NOTE: no reset here -- contents are only used while the matching valid bit is set.
    if (advance) begin
      for (int k = 0; k < NREG; k++) begin
        if (stage_vld_d[k]) data_q[k] <= stage_d[k];
      end
    end
  end

endmodule

// File: tb/tb_csmulti_pipe.sv
// Bench for csmulti_pipe: directed tests on an 8x8 / 2-stage instance plus
// random sweeps on four other shapes, all checked through scoreboards
// filled from a plain-arithmetic multiply model.
module tb_csmulti_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int sweeps_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference multiply: operands of width w, product modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] ua, ub, mask2, p;
    longint      sa, sb;
    ua    = {32'd0, a} & ((64'd1 << w) - 64'd1);
    ub    = {32'd0, b} & ((64'd1 << w) - 64'd1);
    mask2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    if (s) begin
      sa = longint'(ua);
      sb = longint'(ub);
      if (ua[w-1]) sa = sa - longint'(64'd1 << w);
      if (ub[w-1]) sb = sb - longint'(64'd1 << w);
      p = sa * sb;
    end else begin
      p = ua * ub;
    end
    return p & mask2;
  endfunction

  // ---------------- main instance: WIDTH=8, STAGES=2 ----------------
  logic        m_rst_n;
  logic        m_in_valid, m_in_ready, m_in_signed;
  logic [7:0]  m_in_a, m_in_b;
  logic        m_out_valid, m_out_ready, m_out_signed;
  logic [15:0] m_out_product;

  typedef struct {
    logic [15:0] p;
    logic        s;
    int          cyc;   // expected output cycle, or -1 when not timed
  } exp_t;
  exp_t m_q[$];

  csmulti_pipe #(.WIDTH(8), .STAGES(2)) u_main (
    .clk(clk), .rst_n(m_rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .in_signed(m_in_signed),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_product(m_out_product), .out_signed(m_out_signed)
  );

  // Offer one operand set (retrying while not ready); lat requests a
  // latency check of exactly 2 cycles from the offer cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] e, input bit lat, input logic rdy);
    exp_t item;
    bit   done;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      m_out_ready = rdy;
      m_in_valid  = 1'b1;
      m_in_a      = a;
      m_in_b      = b;
      m_in_signed = s;
      #1;
      if (m_in_ready) begin
        item.p   = e;
        item.s   = s;
        item.cyc = lat ? cyc + 2 : -1;
        m_q.push_back(item);
        done = 1;
      end
    end
    if (!done) fail($sformatf("send %0d*%0d not accepted within 20 cycles", a, b));
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 50 && m_q.size() != 0; t++) @(negedge clk);
    check(name, m_q.size(), 0);
    idle(2);
  endtask

  // Main monitor: pops and compares on every output transfer.
  initial begin : main_monitor
    exp_t item;
    forever begin
      @(negedge clk);
      #2;
      if (m_rst_n && m_out_valid && m_out_ready) begin
        if (m_q.size() == 0) begin
          fail($sformatf("main unexpected output %0h (nothing expected)", m_out_product));
        end else begin
          item = m_q.pop_front();
          check("main product", m_out_product, item.p);
          check("main out_signed", m_out_signed, item.s);
          if (item.cyc >= 0) check("main latency cycle", cyc, item.cyc);
        end
      end
    end
  end

  // ---------------- sweep instances ----------------
  logic sw_rst_n;
  initial begin
    sw_rst_n = 1'b0;
    #23 sw_rst_n = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 3;

    logic           in_valid, in_ready, in_signed;
    logic [W-1:0]   in_a, in_b;
    logic           out_valid, out_ready, out_signed;
    logic [2*W-1:0] out_product;
    logic [2*W-1:0] exp_p_q[$];
    logic           exp_s_q[$];
    int             n_acc;

    csmulti_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(sw_rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .out_signed(out_signed)
    );

    initial begin : driver
      logic [31:0] ra, rb;
      logic        rs;
      logic [63:0] e;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      n_acc     = 0;
      repeat (5) @(negedge clk);
      for (int cy = 0; cy < 20000 && n_acc < 2000; cy++) begin
        @(negedge clk);
        ra        = $urandom;
        rb        = $urandom;
        rs        = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 9) < 8);
        in_a      = ra[W-1:0];
        in_b      = rb[W-1:0];
        in_signed = rs;
        out_ready = ($urandom_range(0, 9) < 7);
        #1;
        if (in_valid && in_ready) begin
          e = ref_mul(W, ra, rb, rs);
          exp_p_q.push_back(e[2*W-1:0]);
          exp_s_q.push_back(rs);
          n_acc++;
        end
      end
      if (n_acc < 2000) fail($sformatf("sweep W=%0d S=%0d accepted %0d of 2000", W, S, n_acc));
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cy = 0; cy < 100 && exp_p_q.size() != 0; cy++) @(negedge clk);
      check($sformatf("sweep W=%0d S=%0d leftover results", W, S), exp_p_q.size(), 0);
      sweeps_done++;
    end

    initial begin : monitor
      logic [2*W-1:0] ep;
      logic           es;
      forever begin
        @(negedge clk);
        #2;
        if (sw_rst_n && out_valid && out_ready) begin
          if (exp_p_q.size() == 0) begin
            fail($sformatf("sweep W=%0d S=%0d unexpected output %0h", W, S, out_product));
          end else begin
            ep = exp_p_q.pop_front();
            es = exp_s_q.pop_front();
            check($sformatf("sweep W=%0d S=%0d product", W, S), out_product, ep);
            check($sformatf("sweep W=%0d S=%0d out_signed", W, S), out_signed, es);
          end
        end
      end
    end
  end

  // ---------------- directed sequence on the main instance ----------------
  int unsigned st_a [8] = '{255, 150, 23, 11, 121, 88, 96, 1};
  int unsigned st_b [8] = '{255, 100, 45, 243, 212, 25, 231, 255};

  initial begin : main_seq
    logic [63:0] e;
    logic [7:0]  a8, b8;
    logic        s;
    m_rst_n     = 1'b0;
    m_in_valid  = 1'b0;
    m_in_a      = '0;
    m_in_b      = '0;
    m_in_signed = 1'b0;
    m_out_ready = 1'b0;

    // Reset state
    #8;
    check("reset out_valid", m_out_valid, 0);
    check("reset out_product", m_out_product, 0);
    check("reset out_signed", m_out_signed, 0);
    check("reset in_ready", m_in_ready, 1);
    #4 m_rst_n = 1'b1;

    // Unsigned directed with latency
    send(8'd255, 8'd255, 1'b0, 16'd65025, 1, 1'b1);
    send(8'd150, 8'd100, 1'b0, 16'd15000, 1, 1'b1);
    send(8'd1,   8'd255, 1'b0, 16'd255,   1, 1'b1);
    idle(1);
    drain("unsigned directed drained");

    // Signed directed
    send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 1'b1);
    send(8'h80, 8'h7F, 1'b1, 16'hC080, 1, 1'b1);
    send(8'h80, 8'h80, 1'b1, 16'h4000, 1, 1'b1);
    idle(1);
    drain("signed directed drained");

    // Streaming, alternating mode, back to back
    for (int i = 0; i < 8; i++) begin
      a8 = 8'(st_a[i]);
      b8 = 8'(st_b[i]);
      s  = 1'(i % 2);
      e  = ref_mul(8, {24'd0, a8}, {24'd0, b8}, s);
      send(a8, b8, s, e[15:0], 1, 1'b1);
    end
    idle(1);
    drain("streaming drained");

    // Backpressure: stall with A at the output, B inside, C waiting
    send(8'd150, 8'd100, 1'b0, 16'd15000, 0, 1'b1);
    send(8'd88,  8'd25,  1'b0, 16'd2200,  0, 1'b1);
    @(negedge clk);
    m_out_ready = 1'b0;
    m_in_valid  = 1'b1;
    m_in_a      = 8'd96;
    m_in_b      = 8'd231;
    m_in_signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("stall in_ready", m_in_ready, 0);
      check("stall out_valid", m_out_valid, 1);
      check("stall out_product", m_out_product, 16'd15000);
      check("stall out_signed", m_out_signed, 0);
    end
    send(8'd96, 8'd231, 1'b0, 16'd22176, 0, 1'b1);
    idle(1);
    drain("backpressure drained");

    // Reset mid-operation with two transactions in flight
    send(8'd255, 8'd255, 1'b0, 16'd65025, 0, 1'b0);
    send(8'd150, 8'd100, 1'b0, 16'd15000, 0, 1'b0);
    @(negedge clk);
    m_in_valid = 1'b0;
    #1;
    check("pre-reset out_valid", m_out_valid, 1);
    m_rst_n = 1'b0;
    #1;
    check("mid reset out_valid", m_out_valid, 0);
    check("mid reset in_ready", m_in_ready, 1);
    check("mid reset out_product", m_out_product, 0);
    m_q.delete();
    #2 m_rst_n = 1'b1;
    @(negedge clk);
    m_out_ready = 1'b1;
    idle(5);
    send(8'd23, 8'd45, 1'b0, 16'd1035, 1, 1'b1);
    idle(1);
    drain("post-reset drained");

    // Wait for the sweeps
    for (int t = 0; t < 30000 && sweeps_done < 4; t++) @(negedge clk);
    if (sweeps_done < 4) fail($sformatf("sweeps finished %0d of 4 in time", sweeps_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
